adder_pipe: RTL and testbench
=============================

# adder_pipe

Parametrised, pipelined W-bit add/subtract unit with valid/ready handshake on both sides, carry-out reporting and an accepted-operation counter for energy/activity characterization. The W-bit operation is split into SEGS equal carry-chained segments, one per pipeline stage, so a wide adder closes timing at the flit rate. It replaces the combinational adder in the flit datapath and in characterization benches. Backpressure stalls the pipeline without loss or reordering.

## Interface
- W, 36: operand/result width; must be divisible by SEGS.
- SEGS, 2: pipeline stages = segments; segment width SW = W/SEGS.
- CNT_W, 32: width of op_cnt.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands/op valid.
- in_ready  out  1  unit can accept this cycle.
- op  in  1  0 = add (a+b), 1 = subtract (a-b).
- a  in  W  first operand, unsigned.
- b  in  W  second operand, unsigned.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  W  result.
- cout  out  1  add: carry out; sub: 1 = no borrow.
- cnt_clr  in  1  synchronous clear of op_cnt.
- op_cnt  out  CNT_W  number of accepted operations.

## Operation
- Accept when in_valid && in_ready. Output transfer when out_valid && out_ready.
- Subtract computed as a + ~b + 1 (carry-in 1 into segment 0).
- Stage k (0..SEGS-1) adds segment k of a and b' plus the registered carry from stage k-1. It forwards unprocessed upper operand segments, completed lower result segments, the op bit and carry.
- Per-stage valid bit. Stage k loads when !valid[k] || advance[k+1]. Last stage advances when !out_valid || out_ready. Bubbles collapse.
- in_ready = load enable of stage 0. This is combinational from out_ready through the valid chain, with no registered skid.
- Capacity SEGS results. Order is strictly preserved and nothing is dropped or duplicated.
- sum, cout, out_valid come from the last stage's registers. They are held stable while out_valid && !out_ready.
- op_cnt increments on each accept and saturates at all-ones.
- cnt_clr sets op_cnt to 0. When cnt_clr coincides with an accept, the clear wins and the result is 0.
- Reset state: all valid bits 0, out_valid 0, sum 0, cout 0, op_cnt 0. In_ready is 1 once reset deasserts.
- Reset asserted mid-operation discards all in-flight results with no partial outputs.

## Timing
- Latency is SEGS cycles. An operation accepted in cycle t gives out_valid in cycle t+SEGS when there is no stall.
- Throughput is 1 op/cycle with out_ready held high.
- With out_ready low, the unit accepts exactly SEGS more operations (if empty), then in_ready = 0.
- A result consumed in cycle t frees a slot. In_ready rises in cycle t, which allows a simultaneous accept.
- Carry between segments is registered. There is no combinational path longer than one SW-bit add.

## Configuration
- ADDER_PIPE_SAT_EN defined: the result saturates.
  - Add with cout = 1 gives sum = all-ones.
  - Sub with cout = 0 gives sum = 0.
  - cout still reports the raw carry/borrow.
  - The clamp is applied in the last stage and adds no latency.
- ADDER_PIPE_SAT_EN undefined: the result wraps modulo 2^W. No clamp logic is present.

## Structure
- Package adder_pipe_pkg holds:
  - op encoding constants OP_ADD = 1'b0, OP_SUB = 1'b1;
  - default CNT_W;
  - a function computing SW.
- Sub-module adder_pipe_seg is one register slice. It contains the SW-bit add, carry register, valid bit and pass-through operand/result registers, and is instantiated SEGS times in a generate loop.
- The top contains the handshake chain, the saturation clamp and op_cnt.

## Test plan
- W=36, SEGS=2, add a=36'hFFFFFF000, b=36'h000FFFFFF.
  - Without the macro: sum=36'h000FFEFFF, cout=1, out_valid 2 cycles after accept.
  - With ADDER_PIPE_SAT_EN: sum=36'hFFFFFFFFF.
- Sub a=5, b=7.
  - Without the macro: sum=36'hFFFFFFFFE, cout=0.
  - With the macro: sum=0, cout=0.
  - Sub a=7, b=5: sum=2, cout=1.
- Back-to-back stream of 20 add ops with a=i, b=3i and out_ready=1: results 4i in order at 1/cycle, op_cnt=20.
- out_ready=0 for 6 cycles with in_valid held: exactly 2 accepts, then in_ready=0. On out_ready=1, all results emerge in order with no loss.
- cnt_clr asserted in the same cycle as an accept, with op_cnt=20: op_cnt=0 next cycle. The following accept gives op_cnt=1.
- rst_n pulsed low with 2 ops in flight: out_valid=0, sum=0, op_cnt=0 immediately. After release, no stale results appear and the next op completes normally.

Source files
------------

// File: rtl/adder_pipe_pkg.sv
// Shared constants and helpers for the segmented add/subtract pipeline.
package adder_pipe_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int unsigned CNT_W_DEF = 32;

  // Width of one carry-chained segment; W must be a multiple of SEGS.
  function automatic int unsigned seg_width(input int unsigned w, input int unsigned segs);
    return w / segs;
  endfunction

endpackage

// File: rtl/adder_pipe_seg.sv
// One register slice of the segmented adder: adds the low SW bits of the
// operand vectors, rotates the finished segment into the top of the a-vector
// and shifts the remaining b'-segments down for the next slice.
module adder_pipe_seg
  import adder_pipe_pkg::*;
#(
  parameter int unsigned W  = 36,
  parameter int unsigned SW = 18
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic         i_valid,
  input  logic         i_op,
  input  logic         i_carry,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_valid,
  output logic         o_op,
  output logic         o_carry,
  output logic [W-1:0] o_a,
  output logic [W-1:0] o_b
);

  logic [SW:0]      w_add;
  logic [W+SW-1:0]  w_cat;
  logic [W-1:0]     w_a_next;
  logic [W-1:0]     w_b_next;

  logic             r_valid;
  logic             r_op;
  logic             r_carry;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;

  assign w_add    = {1'b0, i_a[SW-1:0]} + {1'b0, i_b[SW-1:0]} + (SW+1)'(i_carry);
  assign w_cat    = {w_add[SW-1:0], i_a};
  assign w_a_next = W'(w_cat >> SW);
  assign w_b_next = i_b >> SW;

  // Slice register: loads a new entry (or a bubble) when downstream allows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_op    <= OP_ADD;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
    end else if (i_load) begin
      r_valid <= i_valid;
      r_op    <= i_op;
      r_carry <= w_add[SW];
      r_a     <= w_a_next;
      r_b     <= w_b_next;
    end
  end

  assign o_valid = r_valid;
  assign o_op    = r_op;
  assign o_carry = r_carry;
  assign o_a     = r_a;
  assign o_b     = r_b;

endmodule

// File: rtl/adder_pipe.sv
// Pipelined W-bit add/subtract unit, SEGS carry-chained segments, one per
// stage, valid/ready on both sides and a saturating accepted-op counter.
// Optional feature macro: ADDER_PIPE_SAT_EN (clamp result instead of wrap).
module adder_pipe
  import adder_pipe_pkg::*;
#(
  parameter int unsigned W     = 36,
  parameter int unsigned SEGS  = 2,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     sum,
  output logic             cout,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] op_cnt
);

  localparam int unsigned SW = seg_width(W, SEGS);

  logic [W-1:0]     w_a [SEGS+1];
  logic [W-1:0]     w_b [SEGS+1];
  logic [SEGS:0]    w_vld;
  logic [SEGS:0]    w_op;
  logic [SEGS:0]    w_carry;
  logic [SEGS-1:0]  w_load;
  logic             w_accept;
  logic             w_unused;
  logic [CNT_W-1:0] r_op_cnt;

  // Stage-0 operands: subtract is a + ~b + 1.
  assign w_vld[0]   = in_valid;
  assign w_op[0]    = op;
  assign w_carry[0] = (op == OP_SUB);
  assign w_a[0]     = a;
  assign w_b[0]     = (op == OP_SUB) ? ~b : b;

  for (genvar k = 0; k < SEGS; k++) begin : g_seg
    adder_pipe_seg #(
      .W  (W),
      .SW (SW)
    ) u_seg (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_load[k]),
      .i_valid (w_vld[k]),
      .i_op    (w_op[k]),
      .i_carry (w_carry[k]),
      .i_a     (w_a[k]),
      .i_b     (w_b[k]),
      .o_valid (w_vld[k+1]),
      .o_op    (w_op[k+1]),
      .o_carry (w_carry[k+1]),
      .o_a     (w_a[k+1]),
      .o_b     (w_b[k+1])
    );
  end

  // Load-enable chain: a stage loads when empty or when its successor loads.
  always_comb begin
    w_load         = '0;
    w_load[SEGS-1] = !w_vld[SEGS] || out_ready;
    for (int k = int'(SEGS) - 2; k >= 0; k--) begin
      w_load[k] = !w_vld[k+1] || w_load[k+1];
    end
  end

  assign in_ready  = w_load[0];
  assign w_accept  = in_valid && in_ready;
  assign out_valid = w_vld[SEGS];
  assign cout      = w_carry[SEGS];

`ifdef ADDER_PIPE_SAT_EN
  // Clamp on the last stage's registered result: overflow -> all-ones, underflow -> 0.
  always_comb begin
    sum = w_a[SEGS];
    if (w_op[SEGS] == OP_ADD && w_carry[SEGS]) begin
      sum = '1;
    end else if (w_op[SEGS] == OP_SUB && !w_carry[SEGS]) begin
      sum = '0;
    end
  end
  assign w_unused = ^w_b[SEGS];
`else
  assign sum      = w_a[SEGS];
  assign w_unused = ^{w_b[SEGS], w_op[SEGS]};
`endif

  // Accepted-operation counter: clear wins over increment, saturates at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_cnt <= '0;
    end else if (cnt_clr) begin
      r_op_cnt <= '0;
    end else if (w_accept && (r_op_cnt != '1)) begin
      r_op_cnt <= r_op_cnt + CNT_W'(1);
    end
  end

  assign op_cnt = r_op_cnt;

endmodule

// File: tb/tb_adder_pipe.sv
// Bench for adder_pipe (W=36, SEGS=2): vector table plus scoreboard queue,
// and hand sequences for stall, counter clear and mid-flight reset.
module tb_adder_pipe;

  localparam int unsigned W = 36;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         cnt_clr;
  logic [31:0]  op_cnt;

  adder_pipe #(.W(W), .SEGS(2), .CNT_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .cnt_clr   (cnt_clr),
    .op_cnt    (op_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] s;
    logic         c;
  } vec_t;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
  } exp_t;

  vec_t  vecs [8];
  exp_t  sb [$];
  int    n_vec = 0;
  int    n_err = 0;
  int    cyc = 0;
  int    last_acc_cyc = 0;
  int    last_pop_cyc = 0;
  logic  prev_stall = 1'b0;
  logic [W:0] prev_out = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on each transfer, checks hold under stall.
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) check("hold_stable", 64'({cout, sum}), 64'(prev_out));
      prev_stall = out_valid && !out_ready;
      prev_out   = {cout, sum};
      if (out_valid && out_ready) begin
        last_pop_cyc = cyc;
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_output: got sum %h with empty scoreboard", sum);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sum", 64'(sum), 64'(e.s));
          check("cout", 64'(cout), 64'(e.c));
        end
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Drive one op, wait (bounded) for acceptance, push its expected result.
  task automatic send(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic [W-1:0] es, input logic ec);
    bit ok;
    exp_t e;
    ok = 1'b0;
    in_valid = 1'b1; op = o; a = x; b = y;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout: in_ready stayed 0, required 1");
    end else begin
      e.s = es; e.c = ec;
      sb.push_back(e);
      last_acc_cyc = cyc;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (sb.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_acc;
    int n_acc;

    // Vector table: op, a, b, expected sum, expected cout.
    vecs[0] = '{1'b0, 36'hFFFFFF000, 36'h000FFFFFF, 36'h000FFEFFF, 1'b1};
    vecs[1] = '{1'b1, 36'd5,         36'd7,         36'hFFFFFFFFE, 1'b0};
    vecs[2] = '{1'b1, 36'd7,         36'd5,         36'd2,         1'b1};
    vecs[3] = '{1'b0, 36'd1,         36'd2,         36'd3,         1'b0};
    vecs[4] = '{1'b1, 36'd0,         36'd0,         36'd0,         1'b1};
    vecs[5] = '{1'b0, 36'hFFFFFFFFF, 36'd1,         36'd0,         1'b1};
    vecs[6] = '{1'b0, 36'h00003FFFF, 36'd1,         36'h000040000, 1'b0};
    vecs[7] = '{1'b1, 36'h000040000, 36'd1,         36'h00003FFFF, 1'b1};
`ifdef ADDER_PIPE_SAT_EN
    vecs[0].s = 36'hFFFFFFFFF;
    vecs[1].s = 36'd0;
    vecs[5].s = 36'hFFFFFFFFF;
`endif

    rst_n = 1'b0; in_valid = 1'b0; op = 1'b0; a = '0; b = '0;
    out_ready = 1'b1; cnt_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    check("rst_op_cnt", 64'(op_cnt), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // First vector alone: out_valid exactly two cycles after accept.
    send(vecs[0].op, vecs[0].a, vecs[0].b, vecs[0].s, vecs[0].c);
    @(negedge clk);
    check("latency_c1", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("latency_c2", 64'(out_valid), 64'd1);
    wait_drain();

    for (int i = 1; i < 8; i++) send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].c);
    wait_drain();
    check("op_cnt_table", 64'(op_cnt), 64'd8);

    cnt_clr = 1'b1;
    @(posedge clk); #1 cnt_clr = 1'b0;
    check("op_cnt_clr", 64'(op_cnt), 64'd0);

    // Back-to-back stream of 20 adds.
    for (int i = 0; i < 20; i++) begin
      send(1'b0, W'(i), W'(3 * i), W'(4 * i), 1'b0);
      if (i == 0) first_acc = last_acc_cyc;
    end
    wait_drain();
    check("stream_op_cnt", 64'(op_cnt), 64'd20);
    check("stream_span", 64'(last_pop_cyc - first_acc), 64'd21);

    // Clear coinciding with an accept: clear wins.
    cnt_clr = 1'b1;
    send(1'b0, 36'd10, 36'd20, 36'd30, 1'b0);
    cnt_clr = 1'b0;
    check("clr_vs_accept", 64'(op_cnt), 64'd0);
    send(1'b0, 36'd11, 36'd22, 36'd33, 1'b0);
    check("cnt_after_clr", 64'(op_cnt), 64'd1);
    wait_drain();

    // Backpressure: in_valid held for 6 cycles with out_ready low.
    out_ready = 1'b0;
    n_acc = 0;
    in_valid = 1'b1; op = 1'b0; a = 36'd100; b = 36'd0;
    for (int j = 0; j < 6; j++) begin
      bit took;
      took = 1'b0;
      @(negedge clk);
      if (in_ready) begin
        exp_t e;
        e.s = a + b; e.c = 1'b0;
        sb.push_back(e);
        n_acc++;
        took = 1'b1;
      end
      @(posedge clk); #1;
      if (took) begin a = a + 36'd1; b = b + 36'd1; end
    end
    in_valid = 1'b0;
    check("stall_accepts", 64'(n_acc), 64'd2);
    check("stall_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    wait_drain();
    check("stall_no_loss", 64'(sb.size()), 64'd0);

    // Reset with two ops in flight.
    out_ready = 1'b0;
    send(1'b0, 36'd1000, 36'd1, 36'd1001, 1'b0);
    send(1'b0, 36'd2000, 36'd2, 36'd2002, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_sum", 64'(sum), 64'd0);
    check("midrst_op_cnt", 64'(op_cnt), 64'd0);
    sb.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("no_stale", 64'(out_valid), 64'd0);
    send(1'b1, 36'd50, 36'd8, 36'd42, 1'b1);
    wait_drain();
    check("post_rst_cnt", 64'(op_cnt), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
